// File: rtl/fft_pkg.sv
// Shared FFT definitions: sequencer states, length limits and the legal-length test.
package fft_pkg;

  localparam int MAX_FFT_LENGTH_LOG2 = 12;
  localparam int FFT_MIN_LEN_LOG2    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } twaddr_state_e;

  function automatic logic len_is_legal(input logic [3:0] len_log2, input int max_log2);
    return (int'(len_log2) >= FFT_MIN_LEN_LOG2) && (int'(len_log2) <= max_log2);
  endfunction

endpackage

// File: rtl/fft_bfly_counter.sv
// Nested stage/butterfly counter for an FFT of 2^len_log2_i points.
// Exposes the position after the next advance so the caller can register it.
module fft_bfly_counter
  import fft_pkg::*;
#(
  parameter int MAX_LOG2 = MAX_FFT_LENGTH_LOG2
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  clear_i,
  input  logic                  advance_i,
  input  logic [3:0]            len_log2_i,
  output logic                  wrap_o,
  output logic                  last_o,
  output logic [3:0]            stage_next_o,
  output logic [MAX_LOG2-2:0]   bfly_next_o,
  output logic                  last_next_o
);

  localparam int BFLY_W = MAX_LOG2 - 1;

  logic [3:0]        stage_reg;
  logic [BFLY_W-1:0] bfly_reg;
  logic [BFLY_W-1:0] bfly_limit;
  logic [3:0]        stage_limit;

  // Butterflies per stage is N/2, so the wrap point is 2^(L-1)-1.
  assign bfly_limit  = (BFLY_W'(1) << (len_log2_i - 4'd1)) - BFLY_W'(1);
  assign stage_limit = len_log2_i - 4'd1;

  assign wrap_o = (bfly_reg == bfly_limit);
  assign last_o = wrap_o && (stage_reg == stage_limit);

  assign bfly_next_o  = wrap_o ? '0 : bfly_reg + BFLY_W'(1);
  assign stage_next_o = wrap_o ? stage_reg + 4'd1 : stage_reg;
  assign last_next_o  = (bfly_next_o == bfly_limit) && (stage_next_o == stage_limit);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stage_reg <= '0;
      bfly_reg  <= '0;
    end else if (clear_i) begin
      stage_reg <= '0;
      bfly_reg  <= '0;
    end else if (advance_i) begin
      stage_reg <= stage_next_o;
      bfly_reg  <= bfly_next_o;
    end
  end

endmodule

// File: rtl/fft_twiddle_addr_gen.sv
// Twiddle-ROM address sequencer for a radix-2 DIT FFT: one address per butterfly,
// normalised to the maximum transform length, over a valid/ready handshake.
module fft_twiddle_addr_gen
  import fft_pkg::*;
#(
  parameter int MAX_FFT_LENGTH_LOG2 = fft_pkg::MAX_FFT_LENGTH_LOG2,
  parameter int ADDR_WIDTH          = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic [3:0]            fft_len_log2_i,
  input  logic                  abort_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  addr_valid_o,
  input  logic                  addr_ready_i,
  output logic [3:0]            stage_o,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int BFLY_W = MAX_FFT_LENGTH_LOG2 - 1;

  twaddr_state_e state_reg, state_next;

  logic [3:0]            len_reg;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [3:0]            stage_reg, stage_next;
  logic                  last_reg, last_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;

  logic              len_legal;
  logic              start_ok;
  logic              handshake;
  logic              cnt_wrap;
  logic              cnt_last;
  logic [3:0]        cnt_stage_next;
  logic [BFLY_W-1:0] cnt_bfly_next;
  logic              cnt_last_next;
  logic [BFLY_W-1:0] bfly_mask;
  logic [3:0]        exp_shift;
  logic [BFLY_W-1:0] exp_next;

  assign len_legal = len_is_legal(fft_len_log2_i, MAX_FFT_LENGTH_LOG2);
  assign start_ok  = (state_reg == IDLE) && start_i && len_legal && !abort_i;
  assign handshake = (state_reg == RUN) && addr_ready_i && !abort_i;

  fft_bfly_counter #(
    .MAX_LOG2 (MAX_FFT_LENGTH_LOG2)
  ) u_counter (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .clear_i      (start_ok),
    .advance_i    (handshake),
    .len_log2_i   (len_reg),
    .wrap_o       (cnt_wrap),
    .last_o       (cnt_last),
    .stage_next_o (cnt_stage_next),
    .bfly_next_o  (cnt_bfly_next),
    .last_next_o  (cnt_last_next)
  );

  // (b mod 2^s) << (L-1-s) << (MAX-L) collapses to (b mod 2^s) << (MAX-1-s),
  // so the address does not depend on L at all.
  for (genvar gi = 0; gi < BFLY_W; gi++) begin : g_mask
    assign bfly_mask[gi] = (gi < int'(cnt_stage_next));
  end

  assign exp_shift = 4'(BFLY_W) - cnt_stage_next;
  assign exp_next  = (cnt_bfly_next & bfly_mask) << exp_shift;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      addr_reg  <= '0;
      stage_reg <= '0;
      last_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_ok) len_reg <= fft_len_log2_i;
      addr_reg  <= addr_next;
      stage_reg <= stage_next;
      last_reg  <= last_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort_i) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE:    if (start_i && len_legal) state_next = RUN;
        RUN:     if (handshake && cnt_last) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    addr_next  = addr_reg;
    stage_next = stage_reg;
    last_next  = last_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    if (abort_i) begin
      addr_next  = '0;
      stage_next = '0;
      last_next  = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          addr_next  = '0;
          stage_next = '0;
          last_next  = 1'b0;
          err_next   = start_i && !len_legal;
        end
        RUN: begin
          if (handshake) begin
            if (cnt_last) begin
              addr_next  = '0;
              stage_next = '0;
              last_next  = 1'b0;
              done_next  = 1'b1;
            end else begin
              addr_next  = ADDR_WIDTH'(exp_next);
              stage_next = cnt_stage_next;
              last_next  = cnt_last_next;
            end
          end
        end
        default: begin
          addr_next  = '0;
          stage_next = '0;
          last_next  = 1'b0;
        end
      endcase
    end
  end

  // cnt_wrap is only needed inside the counter for the stage step.
  logic unused_wrap;
  assign unused_wrap = cnt_wrap;

  assign addr_o       = addr_reg;
  assign addr_valid_o = (state_reg == RUN);
  assign busy_o       = (state_reg == RUN);
  assign stage_o      = stage_reg;
  assign last_o       = last_reg;
  assign done_o       = done_reg;
  assign err_o        = err_reg;

endmodule

// File: tb/tb_fft_twiddle_addr_gen.sv
// Bench for fft_twiddle_addr_gen: a reference model queues the expected address
// stream per transform and each output cycle is compared against it.
module tb_fft_twiddle_addr_gen;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic        clk_i;
  logic        reset_n_i;
  logic        start_i;
  logic [3:0]  fft_len_log2_i;
  logic        abort_i;
  logic [15:0] addr_o;
  logic        addr_valid_o;
  logic        addr_ready_i;
  logic [3:0]  stage_o;
  logic        last_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  fft_twiddle_addr_gen #(
    .MAX_FFT_LENGTH_LOG2 (12),
    .ADDR_WIDTH          (16)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .start_i        (start_i),
    .fft_len_log2_i (fft_len_log2_i),
    .abort_i        (abort_i),
    .addr_o         (addr_o),
    .addr_valid_o   (addr_valid_o),
    .addr_ready_i   (addr_ready_i),
    .stage_o        (stage_o),
    .last_o         (last_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  stage;
    logic        last;
  } exp_t;

  typedef struct {
    logic [3:0] len;
    bit         stall;
    bit         poke_run;
    bit         poke_done;
    int         exp_n;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;
  int   hs_count = 0;
  int   m_state  = M_IDLE;
  bit   exp_err  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=stuck required=progress (t=%0t)", name, $time);
  endtask

  function automatic logic [15:0] model_addr(input int l, input int s, input int b);
    int k;
    k = (b % (1 << s)) << (l - 1 - s);
    return 16'(k << (12 - l));
  endfunction

  task automatic push_seq(input int l);
    exp_t e;
    int   half;
    half = 1 << (l - 1);
    for (int s = 0; s < l; s++) begin
      for (int b = 0; b < half; b++) begin
        e.addr  = model_addr(l, s, b);
        e.stage = 4'(s);
        e.last  = (s == l - 1) && (b == half - 1);
        sb_q.push_back(e);
      end
    end
  endtask

  // Sample outputs at the falling edge, then drive inputs for the next rising edge
  // and step the model through that edge.
  task automatic do_cycle(input bit rdy, input bit st, input logic [3:0] len, input bit ab);
    exp_t e;
    @(negedge clk_i);
    check("valid", addr_valid_o, m_state == M_RUN);
    check("busy", busy_o, m_state == M_RUN);
    check("done", done_o, m_state == M_DONE);
    check("err", err_o, exp_err);
    if (m_state == M_RUN) begin
      if (sb_q.size() == 0) begin
        fail_now("scoreboard_underrun");
      end else begin
        e = sb_q[0];
        check("addr", addr_o, e.addr);
        check("stage", stage_o, e.stage);
        check("last", last_o, e.last);
      end
    end
    addr_ready_i   = rdy;
    start_i        = st;
    fft_len_log2_i = len;
    abort_i        = ab;
    exp_err        = 1'b0;
    if (ab) begin
      m_state = M_IDLE;
      sb_q.delete();
    end else begin
      case (m_state)
        M_IDLE: if (st) begin
          if (len >= 4'd3 && len <= 4'd12) begin
            push_seq(int'(len));
            m_state = M_RUN;
          end else begin
            exp_err = 1'b1;
          end
        end
        M_RUN: if (rdy && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          hs_count++;
          if (e.last) m_state = M_DONE;
        end
        default: m_state = M_IDLE;
      endcase
    end
  endtask

  task automatic run_vec(input vec_t v);
    int         cyc;
    int         run_cyc;
    int         hs0;
    bit         was_run;
    bit         st;
    logic [3:0] l;
    hs0 = hs_count;
    do_cycle(1'b1, 1'b1, v.len, 1'b0);
    cyc     = 0;
    run_cyc = 0;
    while (m_state != M_IDLE && cyc < v.exp_n * 4 + 50) begin
      was_run = (m_state == M_RUN);
      st = (v.poke_run && was_run && cyc == 3) || (v.poke_done && m_state == M_DONE);
      l  = st ? ((m_state == M_DONE) ? 4'd3 : 4'd5) : v.len;
      do_cycle(v.stall ? 1'($urandom_range(0, 1)) : 1'b1, st, l, 1'b0);
      if (was_run) run_cyc++;
      cyc++;
    end
    if (m_state != M_IDLE) fail_now("timeout");
    do_cycle(1'b1, 1'b0, v.len, 1'b0);
    do_cycle(1'b1, 1'b0, v.len, 1'b0);
    check("transfers", hs_count - hs0, v.exp_n);
    if (!v.stall && v.exp_n > 0) check("run_cycles", run_cyc, v.exp_n);
    $display("vector L=%0d stall=%0d transfers=%0d run_cycles=%0d", v.len, v.stall,
             hs_count - hs0, run_cyc);
  endtask

  task automatic async_reset();
    #2 reset_n_i = 1'b0;
    #1;
    check("rst_addr", addr_o, 0);
    check("rst_valid", addr_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_stage", stage_o, 0);
    check("rst_last", last_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    m_state = M_IDLE;
    sb_q.delete();
    exp_err      = 1'b0;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    addr_ready_i = 1'b0;
    @(posedge clk_i);
    #2 reset_n_i = 1'b1;
  endtask

  initial begin
    vecs[0] = '{len: 4'd3,  stall: 1'b0, poke_run: 1'b1, poke_done: 1'b1, exp_n: 12};
    vecs[1] = '{len: 4'd4,  stall: 1'b1, poke_run: 1'b0, poke_done: 1'b0, exp_n: 32};
    vecs[2] = '{len: 4'd5,  stall: 1'b0, poke_run: 1'b0, poke_done: 1'b1, exp_n: 80};
    vecs[3] = '{len: 4'd12, stall: 1'b0, poke_run: 1'b0, poke_done: 1'b0, exp_n: 24576};
    vecs[4] = '{len: 4'd2,  stall: 1'b0, poke_run: 1'b0, poke_done: 1'b0, exp_n: 0};
    vecs[5] = '{len: 4'd13, stall: 1'b0, poke_run: 1'b0, poke_done: 1'b0, exp_n: 0};
    vecs[6] = '{len: 4'd0,  stall: 1'b0, poke_run: 1'b0, poke_done: 1'b0, exp_n: 0};
    vecs[7] = '{len: 4'd15, stall: 1'b0, poke_run: 1'b0, poke_done: 1'b0, exp_n: 0};

    reset_n_i      = 1'b0;
    start_i        = 1'b0;
    fft_len_log2_i = 4'd0;
    abort_i        = 1'b0;
    addr_ready_i   = 1'b0;
    #1;
    check("rst_addr", addr_o, 0);
    check("rst_valid", addr_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_stage", stage_o, 0);
    check("rst_last", last_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    repeat (2) @(posedge clk_i);
    #2 reset_n_i = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Abort while the fifth address is presented, then restart from scratch.
    do_cycle(1'b1, 1'b1, 4'd3, 1'b0);
    repeat (4) do_cycle(1'b1, 1'b0, 4'd3, 1'b0);
    do_cycle(1'b1, 1'b0, 4'd3, 1'b1);
    do_cycle(1'b1, 1'b0, 4'd3, 1'b0);
    do_cycle(1'b1, 1'b0, 4'd3, 1'b0);
    $display("abort after 4 transfers, restarting L=3");
    run_vec('{len: 4'd3, stall: 1'b0, poke_run: 1'b0, poke_done: 1'b0, exp_n: 12});

    // Abort and start together in IDLE: the start must be dropped.
    do_cycle(1'b1, 1'b1, 4'd3, 1'b1);
    do_cycle(1'b1, 1'b0, 4'd3, 1'b0);
    do_cycle(1'b1, 1'b0, 4'd3, 1'b0);
    $display("abort+start in IDLE ignored");

    // Asynchronous reset in the middle of an L=4 transform.
    do_cycle(1'b1, 1'b1, 4'd4, 1'b0);
    repeat (6) do_cycle(1'($urandom_range(0, 1)), 1'b0, 4'd4, 1'b0);
    async_reset();
    do_cycle(1'b1, 1'b0, 4'd4, 1'b0);
    $display("async reset mid-run, restarting L=4");
    run_vec('{len: 4'd4, stall: 1'b0, poke_run: 1'b1, poke_done: 1'b1, exp_n: 32});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
